// File: rtl/program_loader.sv
// Boot-time instruction loader: streams words into instruction memory from address 0, then runs the CPU until a stop bit retires.
// Optional build macro LOADER_CHECKSUM_EN: the s_last word is treated as a checksum and is not written.
module program_loader #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_last,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [DATA_W-1:0] imem_wdata,
  input  logic              cpu_stop,
  output logic              cpu_run,
  output logic [ADDR_W:0]   word_count,
  output logic              error
);

  typedef enum logic [2:0] {LOAD, FLUSH, RUN, HALT, ERR} state_t;

  localparam logic [ADDR_W:0] CAP = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE = {{ADDR_W{1'b0}}, 1'b1};

  state_t              r_state;
  logic                r_s_ready;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic                r_cpu_run;
  logic [ADDR_W:0]     r_count;
  logic                r_error;
`ifdef LOADER_CHECKSUM_EN
  logic [DATA_W-1:0]   r_sum;
  logic                r_sum_ok;
`endif

  logic w_accept;
  logic w_full;

  assign w_accept = s_valid & r_s_ready;
  assign w_full   = (r_count == CAP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= LOAD;
      r_s_ready <= 1'b0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_cpu_run <= 1'b0;
      r_count   <= '0;
      r_error   <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      r_sum     <= '0;
      r_sum_ok  <= 1'b0;
`endif
    end else begin
      r_we <= 1'b0;
      unique case (r_state)
        LOAD: begin
          r_s_ready <= 1'b1;
          if (w_accept) begin
`ifdef LOADER_CHECKSUM_EN
            // The checksum word is never stored, so it cannot overflow memory.
            if (s_last) begin
              r_s_ready <= 1'b0;
              r_sum_ok  <= (s_data == r_sum);
              r_state   <= FLUSH;
            end else
`endif
            if (w_full) begin
              r_s_ready <= 1'b0;
              r_error   <= 1'b1;
              r_state   <= ERR;
            end else begin
              r_we    <= 1'b1;
              r_addr  <= r_count[ADDR_W-1:0];
              r_wdata <= s_data;
              r_count <= r_count + ONE;
`ifdef LOADER_CHECKSUM_EN
              r_sum   <= r_sum + s_data;
`endif
              if (s_last) begin
                r_s_ready <= 1'b0;
                r_state   <= FLUSH;
              end
            end
          end
        end
        FLUSH: begin
          r_s_ready <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
          if (r_sum_ok) begin
            r_cpu_run <= 1'b1;
            r_state   <= RUN;
          end else begin
            r_error   <= 1'b1;
            r_state   <= ERR;
          end
`else
          r_cpu_run <= 1'b1;
          r_state   <= RUN;
`endif
        end
        RUN: begin
          if (cpu_stop) begin
            r_cpu_run <= 1'b0;
            r_state   <= HALT;
          end
        end
        HALT: begin
          r_cpu_run <= 1'b0;
          r_s_ready <= 1'b0;
        end
        ERR: begin
          r_cpu_run <= 1'b0;
          r_s_ready <= 1'b0;
          r_error   <= 1'b1;
        end
        default: r_state <= ERR;
      endcase
    end
  end

  assign s_ready    = r_s_ready;
  assign imem_we    = r_we;
  assign imem_addr  = r_addr;
  assign imem_wdata = r_wdata;
  assign cpu_run    = r_cpu_run;
  assign word_count = r_count;
  assign error      = r_error;

endmodule

// File: tb/tb_program_loader.sv
// Randomized self-checking bench for program_loader against a transaction-level reference model.
// Build with LOADER_CHECKSUM_EN defined to exercise the checksum variant.
module tb_program_loader;

  localparam int unsigned AW  = 3;
  localparam int unsigned DW  = 32;
  localparam int unsigned CAP = 1 << AW;
`ifdef LOADER_CHECKSUM_EN
  localparam bit CSUM = 1'b1;
`else
  localparam bit CSUM = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [DW-1:0] s_data = '0;
  logic          s_last = 1'b0;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [DW-1:0] imem_wdata;
  logic          cpu_stop = 1'b0;
  logic          cpu_run;
  logic [AW:0]   word_count;
  logic          error;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic [DW-1:0] prog[$];

  program_loader #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_stop(cpu_stop), .cpu_run(cpu_run), .word_count(word_count), .error(error)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_ready"}, 64'(s_ready), 64'd0);
    check_eq({tag, "_we"}, 64'(imem_we), 64'd0);
    check_eq({tag, "_addr"}, 64'(imem_addr), 64'd0);
    check_eq({tag, "_wdata"}, 64'(imem_wdata), 64'd0);
    check_eq({tag, "_run"}, 64'(cpu_run), 64'd0);
    check_eq({tag, "_count"}, 64'(word_count), 64'd0);
    check_eq({tag, "_error"}, 64'(error), 64'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; s_valid = 1'b0; s_last = 1'b0; cpu_stop = 1'b0;
    #3;
    check_idle_outputs("rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_eq("rst_ready_rise", 64'(s_ready), 64'd1);
  endtask

  // Loads prog[] with gap_pct% idle cycles; abort_at>=0 pulls reset after that many accepts.
  task automatic run_prog(input int gap_pct, input int abort_at);
    int n, idx, cnt, cyc, runlen;
    bit v, done, ovf, csum_ok, exp_we;
    logic [DW-1:0] sum;
    n = prog.size(); idx = 0; cnt = 0; cyc = 0; sum = '0;
    done = 1'b0; ovf = 1'b0; csum_ok = 1'b1;
    do_reset();
    while (!done && !ovf && cyc < 400) begin
      @(negedge clk);
      v = ($urandom_range(99) >= gap_pct);
      s_valid = v;
      s_data  = v ? prog[idx] : DW'($urandom);
      s_last  = v ? (idx == n - 1) : 1'($urandom_range(1));
      cpu_stop = 1'($urandom_range(1));
      @(posedge clk); #1;
      cyc++;
      exp_we = 1'b0;
      if (v) begin
        if (CSUM && idx == n - 1) begin
          csum_ok = (prog[idx] == sum);
          done = 1'b1;
        end else if (cnt == CAP) begin
          ovf = 1'b1;
        end else begin
          exp_we = 1'b1;
          check_eq("wr_addr", 64'(imem_addr), 64'(cnt % CAP));
          check_eq("wr_data", 64'(imem_wdata), 64'(prog[idx]));
          cnt++;
          sum += prog[idx];
          if (idx == n - 1) done = 1'b1;
        end
        idx++;
      end
      check_eq("ld_we", 64'(imem_we), 64'(exp_we));
      check_eq("ld_count", 64'(word_count), 64'(cnt));
      check_eq("ld_error", 64'(error), 64'(ovf));
      check_eq("ld_ready", 64'(s_ready), 64'(!(done || ovf)));
      check_eq("ld_run", 64'(cpu_run), 64'd0);
      if (abort_at >= 0 && idx == abort_at) begin
        #2 rst_n = 1'b0;
        #1 check_idle_outputs("abort");
        return;
      end
    end
    if (!done && !ovf) begin
      check_eq("load_timeout", 64'd0, 64'd1);
      return;
    end
    s_valid = 1'b0;
    if (done) begin
      @(negedge clk);
      s_valid = 1'($urandom_range(1)); s_data = DW'($urandom); s_last = 1'($urandom_range(1));
      cpu_stop = 1'b0;
      @(posedge clk); #1;
      check_eq("fl_run", 64'(cpu_run), 64'(csum_ok));
      check_eq("fl_error", 64'(error), 64'(!csum_ok));
      check_eq("fl_we", 64'(imem_we), 64'd0);
      check_eq("fl_ready", 64'(s_ready), 64'd0);
      check_eq("fl_count", 64'(word_count), 64'(cnt));
      if (csum_ok) begin
        runlen = $urandom_range(4);
        for (int i = 0; i < runlen; i++) begin
          @(negedge clk); cpu_stop = 1'b0; s_valid = 1'($urandom_range(1));
          @(posedge clk); #1;
          check_eq("run_run", 64'(cpu_run), 64'd1);
          check_eq("run_ready", 64'(s_ready), 64'd0);
          check_eq("run_we", 64'(imem_we), 64'd0);
        end
        @(negedge clk); cpu_stop = 1'b1;
        @(posedge clk); #1;
        check_eq("stop_run", 64'(cpu_run), 64'd0);
      end
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      cpu_stop = 1'($urandom_range(1)); s_valid = 1'($urandom_range(1)); s_data = DW'($urandom);
      @(posedge clk); #1;
      check_eq("park_run", 64'(cpu_run), 64'd0);
      check_eq("park_ready", 64'(s_ready), 64'd0);
      check_eq("park_we", 64'(imem_we), 64'd0);
      check_eq("park_error", 64'(error), 64'(ovf || !csum_ok));
      check_eq("park_count", 64'(word_count), 64'(cnt));
    end
    s_valid = 1'b0; cpu_stop = 1'b0;
  endtask

  initial begin
    int n;
    logic [DW-1:0] s;
    // three words, s_valid held high
    prog = '{32'h0884_6000, 32'h0000_0000, 32'h0884_6001};
    run_prog(0, -1);
    // gapped stream
    prog = '{32'h1234_5678, 32'h9abc_def1};
    run_prog(60, -1);
    // one more than capacity
    prog.delete();
    for (int i = 0; i < CAP + 1; i++) prog.push_back(DW'($urandom));
    run_prog(0, -1);
    // exactly capacity
    prog.delete();
    for (int i = 0; i < CAP; i++) prog.push_back(DW'($urandom));
    run_prog(20, -1);
    // single-word program
    prog = '{(CSUM ? 32'h0 : 32'hdead_beef)};
    run_prog(0, -1);
    // reset after 2 of 4 words, then reload
    prog = '{32'h11, 32'h22, 32'h33, 32'h44};
    run_prog(0, 2);
    run_prog(30, -1);
`ifdef LOADER_CHECKSUM_EN
    prog = '{32'd5, 32'd7, 32'd12};
    run_prog(0, -1);
    prog = '{32'd5, 32'd7, 32'd13};
    run_prog(0, -1);
`endif
    for (int t = 0; t < 30; t++) begin
      n = $urandom_range(1, CAP + 2);
      prog.delete(); s = '0;
      for (int i = 0; i < n - 1; i++) begin
        prog.push_back(DW'($urandom));
        s += prog[i];
      end
      if (CSUM) prog.push_back(s + DW'($urandom_range(3) == 0));
      else      prog.push_back(DW'($urandom));
      run_prog($urandom_range(70), ($urandom_range(7) == 0) ? int'($urandom_range(1, n)) : -1);
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish, got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
